// File: rtl/aes_pkg.sv
// Shared definitions for the byte-serial AES datapath: read-order codes and
// the 16-element ShiftRows / InvShiftRows source-index mapping.
package aes_pkg;

    localparam logic [1:0] RD_LINEAR   = 2'd0;
    localparam logic [1:0] RD_SHIFT    = 2'd1;
    localparam logic [1:0] RD_INVSHIFT = 2'd2;

    // State is column-major: j = {column, row}. The 2-bit column arithmetic wraps mod 4.
    function automatic logic [3:0] perm16(input logic [3:0] j, input logic [1:0] mode);
        logic [1:0] r;
        logic [1:0] c;
        r = j[1:0];
        c = j[3:2];
        case (mode)
            RD_SHIFT:    perm16 = {2'(c + r), r};
            RD_INVSHIFT: perm16 = {2'(c - r), r};
            default:     perm16 = j;
        endcase
    endfunction

endpackage

// File: rtl/aes_state_perm.sv
// Combinational read-index permutation: element position within a block and
// read mode to the storage address. Only a 16-element state has row shifts.
module aes_state_perm
    import aes_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] idx,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] addr
);

    generate
        if (DEPTH == 16) begin : g_aes
            assign addr = ADDR_W'(perm16(4'(idx), mode));
        end else begin : g_linear
            logic [1:0] unused_mode;
            assign unused_mode = mode;
            assign addr        = idx;
        end
    endgenerate

endmodule

// File: rtl/aes_state_buf.sv
// Ping-pong state buffer: byte stream in, two self-addressed banks, byte stream
// out in linear / ShiftRows / InvShiftRows order with valid/ready on both sides.
module aes_state_buf
    import aes_pkg::*;
#(
    parameter int   DATA_W = 8,
    parameter int   DEPTH  = 16,
    localparam int  ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        rd_mode,
    input  logic [DATA_W-1:0] in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [1:0]        full_cnt
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [1:0]        full_reg;
    logic              wr_bank_reg;
    logic              rd_bank_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [1:0]        blk_mode_reg;
    logic [DATA_W-1:0] out_reg;
    logic              out_valid_reg;
    logic              out_last_reg;

    logic              wr_en;
    logic              wr_done;
    logic              fetch;
    logic              rd_done;
    logic [1:0]        cur_mode;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] bank_rd [2];

    assign in_ready = !full_reg[wr_bank_reg];
    assign wr_en    = in_valid && in_ready && !flush;
    assign wr_done  = wr_en && (wr_ptr_reg == LAST_IDX);
    assign fetch    = full_reg[rd_bank_reg] && (!out_valid_reg || out_ready) && !flush;
    assign rd_done  = fetch && (rd_ptr_reg == LAST_IDX);
    // The first fetch of a block uses the live mode, which is also latched for the rest.
    assign cur_mode = (rd_ptr_reg == '0) ? rd_mode : blk_mode_reg;

    aes_state_perm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_perm (
        .idx  (rd_ptr_reg),
        .mode (cur_mode),
        .addr (rd_addr)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [DATA_W-1:0] mem_reg [DEPTH];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_reg[i] <= '0;
                    end
                end else if (wr_en && (wr_bank_reg == 1'(gi))) begin
                    mem_reg[wr_ptr_reg] <= in;
                end
            end

            assign bank_rd[gi] = mem_reg[rd_addr];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_reg      <= '0;
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            blk_mode_reg  <= RD_LINEAR;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else if (flush) begin
            full_reg      <= '0;
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (wr_done) begin
                    full_reg[wr_bank_reg] <= 1'b1;
                    wr_ptr_reg            <= '0;
                    wr_bank_reg           <= !wr_bank_reg;
                end
            end
            if (fetch) begin
                out_reg       <= bank_rd[rd_bank_reg];
                out_valid_reg <= 1'b1;
                out_last_reg  <= rd_done;
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                if (rd_ptr_reg == '0) begin
                    blk_mode_reg <= rd_mode;
                end
                if (rd_done) begin
                    full_reg[rd_bank_reg] <= 1'b0;
                    rd_ptr_reg            <= '0;
                    rd_bank_reg           <= !rd_bank_reg;
                end
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign full_cnt  = 2'({1'b0, full_reg[0]} + {1'b0, full_reg[1]});

endmodule

// File: tb/tb_aes_state_buf.sv
// Self-checking bench for aes_state_buf: a block-queue reference model checked
// every cycle, table-driven read orders, and hand-written corner sequences.
module tb_aes_state_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] rd_mode = 2'd0;
    logic [7:0] in_d = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_d;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic [1:0] full_cnt;

    aes_state_buf #(.DATA_W(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .rd_mode   (rd_mode),
        .in        (in_d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .full_cnt  (full_cnt)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] blk_t [16];
    typedef struct {
        logic [1:0] mode;
        logic [7:0] exp [16];
    } vec_t;

    // Reference model: completed blocks waiting to be read, plus the block being filled.
    blk_t       q[$];
    blk_t       part;
    int         part_n;
    logic [7:0] m_out;
    bit         m_valid, m_last, m_acc;
    int         m_idx, m_mode;
    logic [7:0] obs[$];
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_src(input int j, input int mode);
        int r = j % 4;
        int c = j / 4;
        if (mode == 1) return r + 4 * ((c + r) % 4);
        if (mode == 2) return r + 4 * ((c - r + 4) % 4);
        return j;
    endfunction

    task automatic model_clear();
        q.delete();
        part_n  = 0;
        m_valid = 0;
        m_last  = 0;
        m_idx   = 0;
    endtask

    task automatic model_tick();
        m_acc = 0;
        if (flush) begin
            model_clear();
        end else begin
            m_acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && (!m_valid || out_ready)) begin
                if (m_idx == 0) m_mode = int'(rd_mode);
                m_out   = q[0][ref_src(m_idx, m_mode)];
                m_last  = (m_idx == 15);
                m_valid = 1;
                m_idx++;
                if (m_idx == 16) begin
                    m_idx = 0;
                    void'(q.pop_front());
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
                m_last  = 0;
            end
            if (m_acc) begin
                part[part_n] = in_d;
                part_n++;
                if (part_n == 16) begin
                    q.push_back(part);
                    part_n = 0;
                end
            end
        end
    endtask

    task automatic step();
        check("in_ready", int'(in_ready), (q.size() < 2) ? 1 : 0);
        check("full_cnt", int'(full_cnt), q.size());
        if (out_valid && out_ready) obs.push_back(out_d);
        model_tick();
        @(posedge clk);
        #1;
        check("out_valid", int'(out_valid), int'(m_valid));
        check("out_last", int'(out_last), int'(m_last));
        check("out", int'(out_d), int'(m_out));
    endtask

    task automatic do_reset();
        flush    = 1'b0;
        in_valid = 1'b0;
        rst      = 1'b0;
        model_clear();
        m_out = 8'd0;
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out", int'(out_d), 0);
        check("rst_full_cnt", int'(full_cnt), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic feed(input logic [7:0] base, input int n);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 200) begin
            in_d     = 8'(int'(base) + k);
            in_valid = 1'b1;
            step();
            if (m_acc) k++;
            cyc++;
        end
        in_valid = 1'b0;
        if (k < n) check("feed_budget", k, n);
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    vec_t vt [3];

    initial begin
        vt[0].mode = 2'd0;
        vt[0].exp  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                       8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
        vt[1].mode = 2'd1;
        vt[1].exp  = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                       8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
        vt[2].mode = 2'd2;
        vt[2].exp  = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                       8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};

        #1;
        // Read-order table: one block of 0x00..0x0F per mode.
        for (int v = 0; v < 3; v++) begin
            do_reset();
            rd_mode   = vt[v].mode;
            out_ready = 1'b1;
            obs.delete();
            feed(8'h00, 16);
            drain(20);
            check("table_count", obs.size(), 16);
            for (int i = 0; i < 16 && i < obs.size(); i++)
                check("table_out", int'(obs[i]), int'(vt[v].exp[i]));
            $display("table mode %0d: %0d elements read back", vt[v].mode, obs.size());
        end

        // Three blocks against a stalled consumer, then release.
        do_reset();
        rd_mode   = 2'd0;
        out_ready = 1'b0;
        obs.delete();
        feed(8'h00, 32);
        in_d     = 8'd32;
        in_valid = 1'b1;
        repeat (3) step();
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_full_cnt", int'(full_cnt), 2);
        check("stall_out_valid", int'(out_valid), 1);
        check("stall_out", int'(out_d), 0);
        out_ready = 1'b1;
        feed(8'd32, 16);
        drain(60);
        check("order_count", obs.size(), 48);
        for (int i = 0; i < 48 && i < obs.size(); i++)
            check("order_out", int'(obs[i]), i);
        $display("stall sequence: %0d elements read back", obs.size());

        // Mode change mid-block applies from the next block only.
        do_reset();
        rd_mode   = 2'd0;
        out_ready = 1'b1;
        obs.delete();
        feed(8'h10, 16);
        for (int cyc = 0; cyc < 40 && obs.size() < 5; cyc++) step();
        rd_mode = 2'd1;
        feed(8'h20, 16);
        drain(40);
        check("modechg_count", obs.size(), 32);
        for (int i = 0; i < 32 && i < obs.size(); i++)
            check("modechg_out", int'(obs[i]),
                  (i < 16) ? 8'h10 + i : 8'h20 + ref_src(i - 16, 1));
        $display("mode change sequence: %0d elements read back", obs.size());

        // Flush with one full bank, a held output and a partial block.
        do_reset();
        rd_mode   = 2'd0;
        out_ready = 1'b0;
        feed(8'h40, 23);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_full_cnt", int'(full_cnt), 0);
        check("flush_out_valid", int'(out_valid), 0);
        check("flush_out_held", int'(out_d), 8'h40);
        obs.delete();
        out_ready = 1'b1;
        feed(8'h80, 16);
        drain(20);
        check("flush_count", obs.size(), 16);
        for (int i = 0; i < 16 && i < obs.size(); i++)
            check("flush_out", int'(obs[i]), 8'h80 + i);
        $display("flush sequence: %0d elements read back", obs.size());

        // Reset in the middle of a block.
        feed(8'hA0, 7);
        do_reset();
        obs.delete();
        feed(8'hC0, 16);
        drain(20);
        check("rstmid_count", obs.size(), 16);
        for (int i = 0; i < 16 && i < obs.size(); i++)
            check("rstmid_out", int'(obs[i]), 8'hC0 + i);
        $display("mid-block reset sequence: %0d elements read back", obs.size());

        // Randomized traffic against the reference model.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_d      = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            rd_mode   = 2'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 299) == 0);
            step();
        end
        flush = 1'b0;
        $display("random traffic: 3000 cycles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
